// File: rtl/go_pkg.sv
// Shared Go definitions: cell encodings, board type, controller state encoding.
// Cell lookup helpers are used by game_controller for legality and suicide tests.
package go_pkg;

    localparam int BOARD_N = 9;

    typedef logic [1:0] cell_t;

    localparam cell_t EMPTY = 2'b00;
    localparam cell_t BLACK = 2'b01;
    localparam cell_t WHITE = 2'b10;

    typedef cell_t [BOARD_N-1:0][BOARD_N-1:0] board_t;

    typedef enum logic [6:0] {
        S_IDLE   = 7'b0000001,
        S_ISSUE  = 7'b0000010,
        S_WAIT   = 7'b0000100,
        S_CHECK  = 7'b0001000,
        S_COMMIT = 7'b0010000,
        S_REJECT = 7'b0100000,
        S_OVER   = 7'b1000000
    } gc_state_e;

    // Mux-based lookup so out-of-range coordinates read as EMPTY instead of X.
    function automatic cell_t get_cell(board_t b, logic [3:0] row, logic [3:0] col);
        cell_t v;
        v = EMPTY;
        for (int r = 0; r < BOARD_N; r++) begin
            for (int c = 0; c < BOARD_N; c++) begin
                if (row == 4'(r) && col == 4'(c)) v = b[r][c];
            end
        end
        return v;
    endfunction

    function automatic cell_t own_colour(logic turn);
        return turn ? WHITE : BLACK;
    endfunction

endpackage

// File: rtl/game_controller_if.sv
// Player and board-update-stage signals of the Go game controller.
interface game_controller_if;
    import go_pkg::*;

    logic       place_in;
    logic       pass_in;
    logic [7:0] cursor_in;
    board_t     upd_board;
    logic       upd_ready;

    board_t     board_bus;
    logic       turn;
    logic [7:0] move_out;
    logic       start_flag;
    logic       move_reject;
    logic       game_over;

    modport master (
        output place_in, pass_in, cursor_in, upd_board, upd_ready,
        input  board_bus, turn, move_out, start_flag, move_reject, game_over
    );

    modport slave (
        input  place_in, pass_in, cursor_in, upd_board, upd_ready,
        output board_bus, turn, move_out, start_flag, move_reject, game_over
    );

endinterface

// File: rtl/board_compare.sv
// Combinational whole-board equality, one comparator per cell.
module board_compare
    import go_pkg::*;
(
    input  board_t a,
    input  board_t b,
    output logic   eq
);

    logic [BOARD_N*BOARD_N-1:0] cell_eq;

    for (genvar r = 0; r < BOARD_N; r++) begin : g_row
        for (genvar c = 0; c < BOARD_N; c++) begin : g_col
            assign cell_eq[r*BOARD_N+c] = (a[r][c] == b[r][c]);
        end
    end

    assign eq = &cell_eq;

endmodule

// File: rtl/game_controller.sv
// Go move sequencer: validates placements, hands them to the update stage, commits results.
// Define KO_CHECK_EN to keep the previous board and refuse ko recaptures.
module game_controller
    import go_pkg::*;
#(
    parameter int PASS_LIMIT = 2,
    parameter int BOARD_N    = go_pkg::BOARD_N
)(
    input  logic              clk_in,
    input  logic              rst_in,
    game_controller_if.slave  gc
);

    localparam int              CNT_W = $clog2(PASS_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIM  = CNT_W'(PASS_LIMIT);
    localparam logic [4:0]       N_LIM = 5'(BOARD_N);

    gc_state_e        state, state_nxt;
    board_t           board_q, cand_q;
    logic             turn_q;
    logic [7:0]       move_q;
    logic [CNT_W-1:0] pass_cnt;

    logic in_range, place_ok, place_bad, pass_go, pass_last, own_ok, ko_hit;

    always_comb begin
        in_range  = ({1'b0, gc.cursor_in[7:4]} < N_LIM) && ({1'b0, gc.cursor_in[3:0]} < N_LIM);
        place_ok  = gc.place_in && in_range &&
                    (get_cell(board_q, gc.cursor_in[7:4], gc.cursor_in[3:0]) == EMPTY);
        place_bad = gc.place_in && !place_ok;
        // A simultaneous place takes priority over the pass.
        pass_go   = gc.pass_in && !gc.place_in;
        pass_last = (pass_cnt >= LIM - CNT_W'(1));
        own_ok    = (get_cell(cand_q, move_q[7:4], move_q[3:0]) == own_colour(turn_q));
    end

`ifdef KO_CHECK_EN
    board_t prev_q;

    board_compare u_ko (
        .a  (cand_q),
        .b  (prev_q),
        .eq (ko_hit)
    );
`else
    assign ko_hit = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (place_ok)                  state_nxt = S_ISSUE;
                else if (place_bad)            state_nxt = S_REJECT;
                else if (pass_go && pass_last) state_nxt = S_OVER;
            end
            S_ISSUE:  state_nxt = S_WAIT;
            S_WAIT:   if (gc.upd_ready) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = (!own_ok || ko_hit) ? S_REJECT : S_COMMIT;
            S_COMMIT: state_nxt = S_IDLE;
            S_REJECT: state_nxt = S_IDLE;
            S_OVER:   state_nxt = S_OVER;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        gc.start_flag  = 1'b0;
        gc.move_reject = 1'b0;
        gc.game_over   = 1'b0;
        case (state)
            S_ISSUE:  gc.start_flag  = 1'b1;
            S_REJECT: gc.move_reject = 1'b1;
            S_OVER:   gc.game_over   = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            board_q  <= '0;
            cand_q   <= '0;
            turn_q   <= 1'b0;
            move_q   <= '0;
            pass_cnt <= '0;
`ifdef KO_CHECK_EN
            prev_q   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (place_ok) begin
                        move_q <= gc.cursor_in;
                    end else if (pass_go) begin
                        turn_q <= ~turn_q;
                        if (pass_cnt != LIM) pass_cnt <= pass_cnt + CNT_W'(1);
                    end
                end
                S_WAIT: if (gc.upd_ready) cand_q <= gc.upd_board;
                S_COMMIT: begin
`ifdef KO_CHECK_EN
                    prev_q   <= board_q;
`endif
                    board_q  <= cand_q;
                    turn_q   <= ~turn_q;
                    pass_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign gc.board_bus = board_q;
    assign gc.turn      = turn_q;
    assign gc.move_out  = move_q;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller; the bench itself acts as the board update stage.
module tb_game_controller;
    import go_pkg::*;

    localparam int LIM     = 2;
    localparam int K_START = 0;
    localparam int K_REJ   = 1;
    localparam int K_STATE = 2;

    typedef struct {
        int         kind;
        board_t     board;
        logic       turn;
        logic       over;
        logic [7:0] mv;
    } exp_t;

    logic clk_in;
    logic rst_in;

    game_controller_if gc();

    game_controller #(.PASS_LIMIT(LIM), .BOARD_N(9)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .gc     (gc)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    exp_t   sbq[$];
    int     n_vec = 0;
    int     n_err = 0;
    board_t m_board, m_prev;
    logic   m_turn, m_over;
    int     m_cnt;
    bit     mon_en = 1'b0;
    board_t pb;
    logic   pt, po;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int kind, input board_t b, input logic t, input logic o,
                        input logic [7:0] mv);
        exp_t e;
        e.kind = kind; e.board = b; e.turn = t; e.over = o; e.mv = mv;
        sbq.push_back(e);
    endtask

    task automatic sb_pop(input int kind);
        exp_t e;
        if (sbq.size() == 0) begin
            chk("sb_unexpected_event", 256'(sbq.size()), 256'(1));
            return;
        end
        e = sbq.pop_front();
        chk("sb_kind", 256'(kind), 256'(e.kind));
        case (kind)
            K_START: chk("sb_move_out", 256'(gc.move_out), 256'(e.mv));
            K_REJ: begin
                chk("sb_rej_board", 256'(gc.board_bus), 256'(e.board));
                chk("sb_rej_turn", 256'(gc.turn), 256'(e.turn));
            end
            default: begin
                chk("sb_board", 256'(gc.board_bus), 256'(e.board));
                chk("sb_turn", 256'(gc.turn), 256'(e.turn));
                chk("sb_over", 256'(gc.game_over), 256'(e.over));
            end
        endcase
    endtask

    // Output monitor: every observable event must match the queue head.
    always @(negedge clk_in) begin
        if (mon_en) begin
            if (gc.start_flag)  sb_pop(K_START);
            if (gc.move_reject) sb_pop(K_REJ);
            if (gc.board_bus != pb || gc.turn != pt || gc.game_over != po) sb_pop(K_STATE);
        end
        pb <= gc.board_bus;
        pt <= gc.turn;
        po <= gc.game_over;
    end

    task automatic model_reset();
        m_board = '0; m_prev = '0; m_turn = 1'b0; m_over = 1'b0; m_cnt = 0;
    endtask

    task automatic do_place(input logic [7:0] cur, input board_t ret, input bit with_pass);
        int    r, c;
        bit    legal, commit;
        cell_t own;
        r = int'(cur[7:4]);
        c = int'(cur[3:0]);
        own = m_turn ? WHITE : BLACK;
        legal = 1'b0;
        commit = 1'b0;
        if (!m_over && r < 9 && c < 9) legal = (m_board[r][c] == EMPTY);
        if (legal) begin
            commit = (ret[r][c] == own);
`ifdef KO_CHECK_EN
            if (ret == m_prev) commit = 1'b0;
`endif
            push(K_START, m_board, m_turn, m_over, cur);
            if (commit) push(K_STATE, ret, ~m_turn, m_over, cur);
            else        push(K_REJ, m_board, m_turn, m_over, cur);
        end else if (!m_over) begin
            push(K_REJ, m_board, m_turn, m_over, cur);
        end
        @(negedge clk_in);
        gc.cursor_in = cur; gc.place_in = 1'b1; gc.pass_in = with_pass;
        @(negedge clk_in);
        gc.place_in = 1'b0; gc.pass_in = 1'b0;
        chk("start_latency", 256'(gc.start_flag), 256'(legal));
        if (!legal) begin
            chk("idle_reject", 256'(gc.move_reject), 256'(!m_over));
            chk("idle_turn", 256'(gc.turn), 256'(m_turn));
            @(negedge clk_in);
            chk("reject_one_cycle", 256'(gc.move_reject), 256'(0));
            return;
        end
        @(negedge clk_in);
        chk("start_one_cycle", 256'(gc.start_flag), 256'(0));
        @(negedge clk_in);
        gc.upd_board = ret; gc.upd_ready = 1'b1;
        @(negedge clk_in);
        gc.upd_ready = 1'b0;
        chk("hold_in_check", 256'(gc.board_bus), 256'(m_board));
        @(negedge clk_in);
        chk("hold_before_commit", 256'(gc.board_bus), 256'(m_board));
        @(negedge clk_in);
        chk("commit_latency", 256'(gc.board_bus), 256'(commit ? ret : m_board));
        if (commit) begin
            m_prev = m_board; m_board = ret; m_turn = ~m_turn; m_cnt = 0;
        end
        @(negedge clk_in);
    endtask

    task automatic do_pass();
        if (!m_over) begin
            m_turn = ~m_turn;
            if (m_cnt < LIM) m_cnt++;
            if (m_cnt >= LIM) m_over = 1'b1;
            push(K_STATE, m_board, m_turn, m_over, 8'h00);
        end
        @(negedge clk_in);
        gc.pass_in = 1'b1;
        @(negedge clk_in);
        gc.pass_in = 1'b0;
        chk("pass_turn", 256'(gc.turn), 256'(m_turn));
        chk("pass_over", 256'(gc.game_over), 256'(m_over));
        @(negedge clk_in);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        board_t b, b0, b1;
        cell_t  own, opp;
        gc.place_in = 1'b0; gc.pass_in = 1'b0; gc.cursor_in = '0;
        gc.upd_board = '0; gc.upd_ready = 1'b0;
        model_reset();
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("rst_board", 256'(gc.board_bus), 256'(0));
        chk("rst_turn", 256'(gc.turn), 256'(0));
        chk("rst_move_out", 256'(gc.move_out), 256'(0));
        chk("rst_start", 256'(gc.start_flag), 256'(0));
        chk("rst_reject", 256'(gc.move_reject), 256'(0));
        chk("rst_over", 256'(gc.game_over), 256'(0));
        mon_en = 1'b1;

        b = '0; b[3][3] = BLACK;
        do_place(8'h33, b, 1'b0);
        chk("first_cell33", 256'(gc.board_bus[3][3]), 256'(BLACK));
        chk("first_turn", 256'(gc.turn), 256'(1));

        do_place(8'h33, b, 1'b0);
        do_place(8'h9A, b, 1'b0);
        do_place(8'h44, m_board, 1'b0);

        b = m_board; b[4][5] = WHITE;
        do_place(8'h45, b, 1'b1);

        do_pass();
        b = m_board; b[5][0] = WHITE;
        do_place(8'h50, b, 1'b0);
        do_pass();

        own = m_turn ? WHITE : BLACK;
        opp = m_turn ? BLACK : WHITE;
        b0 = m_board; b0[7][7] = own;
        do_place(8'h77, b0, 1'b0);
        b1 = b0; b1[7][7] = EMPTY; b1[7][8] = opp;
        do_place(8'h78, b1, 1'b0);
        do_place(8'h77, b0, 1'b0);

        do_pass();
        do_pass();
        b = m_board; b[0][0] = BLACK;
        do_place(8'h00, b, 1'b0);
        do_pass();
        chk("over_sticky", 256'(gc.game_over), 256'(1));

        mon_en = 1'b0;
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
        sbq.delete();
        @(negedge clk_in);
        chk("rst2_over", 256'(gc.game_over), 256'(0));
        gc.cursor_in = 8'h11; gc.place_in = 1'b1;
        @(negedge clk_in);
        gc.place_in = 1'b0;
        chk("rst2_start", 256'(gc.start_flag), 256'(1));
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        b = '0; b[1][1] = BLACK;
        gc.upd_board = b; gc.upd_ready = 1'b1;
        @(negedge clk_in);
        gc.upd_ready = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("late_upd_board", 256'(gc.board_bus), 256'(0));
        chk("late_upd_turn", 256'(gc.turn), 256'(0));
        chk("late_upd_move_out", 256'(gc.move_out), 256'(0));
        chk("late_upd_reject", 256'(gc.move_reject), 256'(0));
        mon_en = 1'b1;
        @(negedge clk_in);

        b = '0; b[2][2] = BLACK;
        do_place(8'h22, b, 1'b0);
        repeat (2) @(negedge clk_in);
        chk("sb_drain", 256'(sbq.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
